// File: rtl/adder_scan_pkg.sv
// Shared types and defaults for the adder scan-test sequencer.
// The optional compare/fail-count feature is selected with ADDER_SCAN_CMP_EN.
package adder_scan_pkg;

    localparam int CHAIN_LEN_DEF = 5;
    localparam int DATA_W_DEF    = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        CAPTURE = 3'd2,
        UNLOAD  = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Counter width able to hold the value n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/adder_scan_shifter.sv
// Shift datapath: a parallel-in/serial-out load register that drives the chain,
// and a serial-in/parallel-out register that collects bits unloaded from it.
module adder_scan_shifter
    import adder_scan_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [CHAIN_LEN-1:0] load_vec,
    input  logic                 shift_load,
    input  logic                 shift_cap,
    input  logic                 ser_in,
    output logic                 ser_out,
    output logic [CHAIN_LEN-1:0] cap_word
);

    localparam int CW1 = CHAIN_LEN - 1;

    logic [CHAIN_LEN-1:0] lreg;
    // Only CHAIN_LEN-1 bits are stored; the final bit is taken live from ser_in
    // so the full word is available on the last unload cycle.
    logic [CW1-1:0]       creg;

    always_ff @(posedge clk) begin
        if (rst) begin
            lreg <= '0;
            creg <= '0;
        end else begin
            if (load) begin
                lreg <= load_vec;
            end else if (shift_load) begin
                lreg <= {lreg[CHAIN_LEN-2:0], 1'b0};
            end

            if (load) begin
                creg <= '0;
            end else if (shift_cap) begin
                creg <= CW1'({creg, ser_in});
            end
        end
    end

    assign ser_out  = lreg[CHAIN_LEN-1];
    assign cap_word = {creg, ser_in};

endmodule

// File: rtl/adder_scan_ctrl.sv
// Scan-test sequencer for the registered adder: load chain, capture once, unload and compare.
// Define ADDER_SCAN_CMP_EN to build the expected-vector comparator and the fail counter.
module adder_scan_ctrl
    import adder_scan_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic                 CK,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [DATA_W-1:0]    pat_a,
    input  logic [DATA_W-1:0]    pat_b,
    input  logic [CHAIN_LEN-1:0] load_vec,
    input  logic [CHAIN_LEN-1:0] exp_vec,
    input  logic                 scan_out,
    output logic                 scan_enable,
    output logic                 scan_in,
    output logic [DATA_W-1:0]    a,
    output logic [DATA_W-1:0]    b,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] captured,
    output logic                 pass
);

    localparam int CW = cnt_w(CHAIN_LEN);

    // Host handshake: start is a single-cycle request honoured only while busy=0
    // (abort in the same cycle wins); each accepted, non-aborted test ends with
    // exactly one done pulse, and captured/pass hold from that pulse until the next accept.

    state_t              state, state_nx;
    logic [CW-1:0]       cnt, cnt_nx;
    logic [DATA_W-1:0]   op_a, op_b;
    logic                accept;
    logic                last;
    logic                load_bit;
    logic [CHAIN_LEN-1:0] cap_word;

    assign accept = (state == IDLE) && start && !abort;
    assign last   = (cnt == CW'(CHAIN_LEN - 1));

    always_ff @(posedge CK) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = LOAD;
                    cnt_nx   = '0;
                end
            end
            LOAD: begin
                if (last) begin
                    state_nx = CAPTURE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            CAPTURE: begin
                state_nx = UNLOAD;
                cnt_nx   = '0;
            end
            UNLOAD: begin
                if (last) begin
                    state_nx = DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
        if (abort && (state != IDLE)) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end
    end

    always_ff @(posedge CK) begin
        if (rst) begin
            op_a <= '0;
            op_b <= '0;
        end else if (accept) begin
            op_a <= pat_a;
            op_b <= pat_b;
        end
    end

    adder_scan_shifter #(
        .CHAIN_LEN (CHAIN_LEN)
    ) u_shifter (
        .clk        (CK),
        .rst        (rst),
        .load       (accept),
        .load_vec   (load_vec),
        .shift_load (state == LOAD),
        .shift_cap  (state == UNLOAD),
        .ser_in     (scan_out),
        .ser_out    (load_bit),
        .cap_word   (cap_word)
    );

    // Outputs are decoded from state so SE/SI drop in the same cycle IDLE is entered.
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign scan_enable = (state == LOAD) || (state == UNLOAD);
    assign scan_in     = (state == LOAD) ? load_bit : 1'b0;
    assign a           = busy ? op_a : '0;
    assign b           = busy ? op_b : '0;

    // Results commit on the edge into DONE, so an abort during unload leaves them untouched.
    always_ff @(posedge CK) begin
        if (rst) begin
            captured <= '0;
        end else if ((state == UNLOAD) && last && !abort) begin
            captured <= cap_word;
        end
    end

`ifdef ADDER_SCAN_CMP_EN
    logic [CHAIN_LEN-1:0] exp_q;
    logic [7:0]           fail_cnt;

    always_ff @(posedge CK) begin
        if (rst) begin
            exp_q <= '0;
        end else if (accept) begin
            exp_q <= exp_vec;
        end
    end

    always_ff @(posedge CK) begin
        if (rst) begin
            pass <= 1'b0;
        end else if ((state == UNLOAD) && last && !abort) begin
            pass <= (cap_word == exp_q);
        end
    end

    always_ff @(posedge CK) begin
        if (rst) begin
            fail_cnt <= '0;
        end else if ((state == DONE) && !pass && (fail_cnt != 8'hFF)) begin
            fail_cnt <= fail_cnt + 8'd1;
        end
    end
`else
    logic unused_exp;
    assign unused_exp = ^exp_vec;
    assign pass       = 1'b0;
`endif

endmodule

// File: tb/tb_adder_scan_ctrl.sv
// Bench for adder_scan_ctrl with a behavioural scan-chain adder attached.
// Expected results come from plain arithmetic on the test operands and the cycle schedule.
module tb_adder_scan_ctrl;

    localparam int CHAIN_LEN = 5;
    localparam int DATA_W    = 4;

    // ---------------- clock / reset ----------------
    logic                 CK = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 abort;
    logic [DATA_W-1:0]    pat_a, pat_b;
    logic [CHAIN_LEN-1:0] load_vec, exp_vec;
    logic                 scan_out;
    logic                 scan_enable, scan_in, busy, done, pass;
    logic [DATA_W-1:0]    a, b;
    logic [CHAIN_LEN-1:0] captured;

    always #5 CK = ~CK;

    adder_scan_ctrl dut (
        .CK          (CK),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .pat_a       (pat_a),
        .pat_b       (pat_b),
        .load_vec    (load_vec),
        .exp_vec     (exp_vec),
        .scan_out    (scan_out),
        .scan_enable (scan_enable),
        .scan_in     (scan_in),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .captured    (captured),
        .pass        (pass)
    );

    // Registered adder with its SDFF chain: scan_in -> sum[0] .. sum[4] -> scan_out.
    logic [CHAIN_LEN-1:0] chain = '0;
    always @(posedge CK) begin
        if (scan_enable) chain <= {chain[CHAIN_LEN-2:0], scan_in};
        else             chain <= CHAIN_LEN'(a) + CHAIN_LEN'(b);
    end
    assign scan_out = chain[CHAIN_LEN-1];

    // ---------------- scoreboard ----------------
    int n_chk  = 0;
    int n_pass = 0;
    logic [CHAIN_LEN-1:0] exp_q[$];
    logic [CHAIN_LEN-1:0] prev_cap  = '0;
    logic                 prev_pass = 1'b0;
    int                   exp_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic exp_pass_of(input logic [CHAIN_LEN-1:0] sum, input logic [CHAIN_LEN-1:0] ev);
`ifdef ADDER_SCAN_CMP_EN
        return sum == ev;
`else
        return (sum == ev) && 1'b0;
`endif
    endfunction

    task automatic check_fail_cnt();
`ifdef ADDER_SCAN_CMP_EN
        check("fail_cnt", 32'(dut.fail_cnt), 32'(exp_fail));
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_se"},   32'(scan_enable), 32'(0));
        check({tag, "_si"},   32'(scan_in),     32'(0));
        check({tag, "_busy"}, 32'(busy),        32'(0));
        check({tag, "_done"}, 32'(done),        32'(0));
        check({tag, "_a"},    32'(a),           32'(0));
        check({tag, "_b"},    32'(b),           32'(0));
        check({tag, "_cap"},  32'(captured),    32'(0));
        check({tag, "_pass"}, 32'(pass),        32'(0));
    endtask

    // ---------------- driver tasks ----------------
    // Runs one test; abort_cyc/rst_cyc/restart_cyc name the cycle (1 = first LOAD
    // cycle) in which that input is raised, 0 meaning never.
    task automatic run_test(input logic [DATA_W-1:0] ta, input logic [DATA_W-1:0] tb,
                            input logic [CHAIN_LEN-1:0] lv, input logic [CHAIN_LEN-1:0] ev,
                            input int abort_cyc, input int rst_cyc, input int restart_cyc);
        logic [CHAIN_LEN-1:0] sum, cap_exp;
        logic ep, killed, live, exp_se, exp_si;
        int kill, idx;
        sum  = CHAIN_LEN'(ta) + CHAIN_LEN'(tb);
        ep   = exp_pass_of(sum, ev);
        kill = (abort_cyc != 0) ? abort_cyc : rst_cyc;
        exp_q.push_back(sum);
        pat_a = ta; pat_b = tb; load_vec = lv; exp_vec = ev; start = 1'b1;
        @(posedge CK); #1;
        start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            killed = (kill != 0) && (c > kill);
            live   = !killed && (c <= 2 * CHAIN_LEN + 2);
            exp_se = live && ((c <= CHAIN_LEN) || (c >= CHAIN_LEN + 2 && c <= 2 * CHAIN_LEN + 1));
            exp_si = 1'b0;
            if (live && c <= CHAIN_LEN) begin
                idx    = CHAIN_LEN - c;
                exp_si = lv[idx];
            end
            check("scan_enable", 32'(scan_enable), 32'(exp_se));
            check("scan_in",     32'(scan_in),     32'(exp_si));
            check("busy",        32'(busy),        32'(live));
            check("done",        32'(done),        32'(live && c == 2 * CHAIN_LEN + 2));
            check("a",           32'(a),           live ? 32'(ta) : 32'(0));
            check("b",           32'(b),           live ? 32'(tb) : 32'(0));
            if (live && c == CHAIN_LEN + 1)
                check("chain_loaded", 32'(chain), 32'(lv));
            if (live && c == 2 * CHAIN_LEN + 2) begin
                cap_exp = exp_q.pop_front();
                check("captured", 32'(captured), 32'(cap_exp));
                check("pass",     32'(pass),     32'(ep));
                prev_cap  = cap_exp;
                prev_pass = ep;
                if (!ep && exp_fail < 255) exp_fail++;
            end
            if (rst_cyc != 0 && c == rst_cyc + 1) check_all_zero("after_rst");
            if (c == abort_cyc) abort = 1'b1;
            if (c == rst_cyc)   rst   = 1'b1;
            if (c == restart_cyc) begin
                start = 1'b1; pat_a = ~ta; pat_b = ~tb; load_vec = ~lv;
            end
            @(posedge CK); #1;
            abort = 1'b0; rst = 1'b0; start = 1'b0;
        end
        if (kill != 0) begin
            void'(exp_q.pop_front());
            if (rst_cyc != 0) begin
                prev_cap = '0; prev_pass = 1'b0; exp_fail = 0;
            end
            check("cap_kept",  32'(captured), 32'(prev_cap));
            check("pass_kept", 32'(pass),     32'(prev_pass));
        end
        check_fail_cnt();
    endtask

    task automatic start_abort_idle();
        pat_a = 4'hA; pat_b = 4'h5; start = 1'b1; abort = 1'b1;
        @(posedge CK); #1;
        start = 1'b0; abort = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("sa_busy", 32'(busy),        32'(0));
            check("sa_se",   32'(scan_enable), 32'(0));
            check("sa_a",    32'(a),           32'(0));
            check("sa_cap",  32'(captured),    32'(prev_cap));
            @(posedge CK); #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DATA_W-1:0]    ra, rb;
        logic [CHAIN_LEN-1:0] rl, re;
        int                   rab;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        pat_a = '0; pat_b = '0; load_vec = '0; exp_vec = '0;
        repeat (3) @(posedge CK);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge CK); #1;
        check_all_zero("idle");
        check_fail_cnt();

        run_test(4'd3,  4'd5,  5'b10101, 5'b01000, 0, 0, 0);
        run_test(4'd15, 4'd15, 5'b01101, 5'b11110, 0, 0, 0);
        run_test(4'd15, 4'd15, 5'b11011, 5'b11111, 0, 0, 0);
        run_test(4'd7,  4'd2,  5'b00111, 5'b01001, 0, 0, 3);
        run_test(4'd9,  4'd12, 5'b11100, 5'b10101, 9, 0, 0);
        start_abort_idle();
        run_test(4'd6,  4'd1,  5'b10010, 5'b00111, 0, 6, 0);
        run_test(4'd0,  4'd0,  5'b11111, 5'b00000, 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            ra  = DATA_W'($urandom_range(0, 15));
            rb  = DATA_W'($urandom_range(0, 15));
            rl  = CHAIN_LEN'($urandom_range(0, 31));
            re  = ($urandom_range(0, 1) == 1) ? CHAIN_LEN'(ra) + CHAIN_LEN'(rb)
                                              : CHAIN_LEN'($urandom_range(0, 31));
            rab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 11) : 0;
            run_test(ra, rb, rl, re, rab, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
